// File: rtl/arb_rr_4x1_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arb_rr_4x1_stage_pkg
// Description : Shared constants and types for the 4-source arbiter stage.
// Revision    : 1.0 - initial release
// ============================================================================
package arb_rr_4x1_stage_pkg;

    localparam int ARB_NSRC  = 4;
    localparam int ARB_IDX_W = 2;

    // Source index: grant index, output source tag and round-robin pointer.
    typedef logic [ARB_IDX_W-1:0] arb_idx_t;

    // Next index after idx, wrapping 3 -> 0.
    function automatic arb_idx_t arb_idx_inc(input arb_idx_t idx);
        return idx + arb_idx_t'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/arb_rr4_gnt.sv
`default_nettype none
// ============================================================================
// Module      : arb_rr4_gnt
// Description : Four-way grant selection. With en=1 the scan starts at
//               rr_ptr and wraps 3->0; with en=0 source 0 has the highest
//               priority. next_ptr is the slot after the winner.
// Revision    : 1.0 - initial release
// ============================================================================
module arb_rr4_gnt
    import arb_rr_4x1_stage_pkg::*;
(
    input  logic [ARB_NSRC-1:0] in_valid,
    input  arb_idx_t            rr_ptr,
    input  logic                en,
    output arb_idx_t            gnt_idx,
    output logic                any_req,
    output arb_idx_t            next_ptr
);

    arb_idx_t w_base;

    assign w_base = en ? rr_ptr : '0;

    // First requesting source found scanning upward from the base, with wrap.
    always_comb begin
        logic     w_found;
        arb_idx_t w_cand;
        gnt_idx = '0;
        w_found = 1'b0;
        w_cand  = '0;
        for (int k = 0; k < ARB_NSRC; k++) begin
            w_cand = w_base + arb_idx_t'(k);
            if (!w_found && in_valid[w_cand]) begin
                gnt_idx = w_cand;
                w_found = 1'b1;
            end
        end
    end

    assign any_req  = |in_valid;
    assign next_ptr = arb_idx_inc(gnt_idx);

endmodule
`default_nettype wire

// File: rtl/mux_nbit_4x1.sv
`default_nettype none
// ============================================================================
// Module      : mux_nbit_4x1
// Description : N-bit wide 4:1 combinational multiplexer.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_nbit_4x1 #(
    parameter int N = 32
) (
    input  logic [N-1:0] a0,
    input  logic [N-1:0] a1,
    input  logic [N-1:0] a2,
    input  logic [N-1:0] a3,
    input  logic [1:0]   sel,
    output logic [N-1:0] y
);

    // Route the selected source to the output.
    always_comb begin
        y = a0;
        case (sel)
            2'd0:    y = a0;
            2'd1:    y = a1;
            2'd2:    y = a2;
            default: y = a3;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/arb_rr_4x1_stage.sv
`default_nettype none
// ============================================================================
// Module      : arb_rr_4x1_stage
// Description : Four-source valid/ready arbiter followed by a single output
//               register stage. Compile-time option ARB_RR_EN selects
//               round-robin arbitration; without it source 0 has fixed
//               highest priority.
// Revision    : 1.0 - initial release
// ============================================================================
module arb_rr_4x1_stage
    import arb_rr_4x1_stage_pkg::*;
#(
    parameter int N = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ARB_NSRC-1:0] in_valid,
    input  logic [N-1:0]        in_data0,
    input  logic [N-1:0]        in_data1,
    input  logic [N-1:0]        in_data2,
    input  logic [N-1:0]        in_data3,
    output logic [ARB_NSRC-1:0] in_ready,
    output logic                out_valid,
    output logic [N-1:0]        out_data,
    output arb_idx_t            out_src,
    input  logic                out_ready
);

    arb_idx_t     w_gnt_idx;
    arb_idx_t     w_next_ptr;
    arb_idx_t     w_rr_ptr;
    logic         w_any_req;
    logic         w_load;
    logic         w_take;
    logic         w_rr_en;
    logic [N-1:0] w_mux_y;

    logic         r_out_valid;
    logic [N-1:0] r_out_data;
    arb_idx_t     r_out_src;

`ifdef ARB_RR_EN
    arb_idx_t     r_rr_ptr;

    assign w_rr_en  = 1'b1;
    assign w_rr_ptr = r_rr_ptr;

    // Pointer moves past the winner only when a grant is actually consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= '0;
        end else if (w_take) begin
            r_rr_ptr <= w_next_ptr;
        end
    end
`else
    logic w_unused_next_ptr;

    assign w_rr_en           = 1'b0;
    assign w_rr_ptr          = '0;
    assign w_unused_next_ptr = ^w_next_ptr;
`endif

    arb_rr4_gnt u_gnt (
        .in_valid (in_valid),
        .rr_ptr   (w_rr_ptr),
        .en       (w_rr_en),
        .gnt_idx  (w_gnt_idx),
        .any_req  (w_any_req),
        .next_ptr (w_next_ptr)
    );

    mux_nbit_4x1 #(
        .N (N)
    ) u_mux (
        .a0  (in_data0),
        .a1  (in_data1),
        .a2  (in_data2),
        .a3  (in_data3),
        .sel (w_gnt_idx),
        .y   (w_mux_y)
    );

    // Register may load when empty or when its word leaves this cycle.
    assign w_load = ~r_out_valid | out_ready;
    assign w_take = w_load & w_any_req;

    // One-hot accept to the winner; suppressed while in reset.
    always_comb begin
        in_ready = '0;
        if (w_take && !rst) begin
            in_ready[w_gnt_idx] = 1'b1;
        end
    end

    // Output stage: capture on transfer, go empty on drain, hold on stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_src   <= '0;
        end else if (w_take) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_mux_y;
            r_out_src   <= w_gnt_idx;
        end else if (w_load) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_src   = r_out_src;

endmodule
`default_nettype wire

// File: tb/tb_arb_rr_4x1_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_arb_rr_4x1_stage
// Description : Self-checking bench for arb_rr_4x1_stage (honours ARB_RR_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_arb_rr_4x1_stage;

`ifdef ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  in_valid;
    logic [31:0] d [4];
    logic [3:0]  in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic [1:0]  out_src;
    logic        out_ready;

    int total = 0;
    int bad   = 0;

    arb_rr_4x1_stage #(.N(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data0  (d[0]),
        .in_data1  (d[1]),
        .in_data2  (d[2]),
        .in_data3  (d[3]),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    // Reference state: what the output register and pointer must hold.
    logic        m_valid = 1'b0, n_valid = 1'b0;
    logic [31:0] m_data  = '0,   n_data  = '0;
    int          m_src   = 0,    n_src   = 0;
    int          m_ptr   = 0,    n_ptr   = 0;
    bit          chk_en  = 1'b0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Mid-cycle: check DUT against the model, then work out the next state.
    always @(negedge clk) begin
        int   win;
        logic [3:0] exp_rdy;
        bool_load: begin end
        win = -1;
        for (int k = 0; k < 4; k++) begin
            int c;
            c = ((RR ? m_ptr : 0) + k) % 4;
            if (win < 0 && in_valid[c]) win = c;
        end
        exp_rdy = 4'b0;
        if (!rst && (!m_valid || out_ready) && win >= 0) exp_rdy[win] = 1'b1;
        if (chk_en) begin
            cmp("in_ready",  32'(in_ready),  32'(exp_rdy));
            cmp("out_valid", 32'(out_valid), 32'(m_valid));
            cmp("out_data",  out_data,       m_data);
            cmp("out_src",   32'(out_src),   32'(m_src));
        end
        n_valid = m_valid; n_data = m_data; n_src = m_src; n_ptr = m_ptr;
        if (rst) begin
            n_valid = 1'b0; n_data = '0; n_src = 0; n_ptr = 0;
        end else if (!m_valid || out_ready) begin
            if (win >= 0) begin
                n_valid = 1'b1; n_data = d[win]; n_src = win; n_ptr = (win + 1) % 4;
            end else begin
                n_valid = 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        m_valid <= n_valid; m_data <= n_data; m_src <= n_src; m_ptr <= n_ptr;
    end

    task automatic step;
        @(posedge clk); #1;
    endtask

    initial begin
        int exp_src;
        rst = 1'b1; in_valid = 4'hF; out_ready = 1'b1;
        for (int k = 0; k < 4; k++) d[k] = 32'hA0 + 32'(k);

        // Reset held two cycles with everyone requesting.
        step; #1; chk_en = 1'b1;
        cmp("rst_in_ready", 32'(in_ready), 32'h0);
        cmp("rst_out_valid", 32'(out_valid), 32'h0);
        cmp("rst_out_data", out_data, 32'h0);
        cmp("rst_out_src", 32'(out_src), 32'h0);
        step; rst = 1'b0; #1;
        cmp("first_grant", 32'(in_ready), 32'h1);

        // Continuous requests with a ready sink.
        for (int k = 0; k < 5; k++) begin
            step; #1;
            exp_src = RR ? (k % 4) : 0;
            cmp("seq_src", 32'(out_src), 32'(exp_src));
            cmp("seq_data", out_data, 32'hA0 + 32'(exp_src));
        end
        step; #1;
        cmp("pre_stall_src", 32'(out_src), RR ? 32'd1 : 32'd0);
        out_ready = 1'b0; #1;
        cmp("stall_in_ready", 32'(in_ready), 32'h0);

        // Three stalled edges: everything frozen.
        for (int k = 0; k < 3; k++) begin
            step;
            if (k == 2) out_ready = 1'b1;
            #1;
            cmp("stall_src", 32'(out_src), RR ? 32'd1 : 32'd0);
            cmp("stall_valid", 32'(out_valid), 32'h1);
        end
        cmp("post_stall_grant", 32'(in_ready), RR ? 32'h4 : 32'h1);
        step; in_valid = 4'b0010; #1;
        cmp("after_stall_src", 32'(out_src), RR ? 32'd2 : 32'd0);
        cmp("sparse_grant", 32'(in_ready), 32'h2);
        step; in_valid = 4'b1000; #1;
        cmp("sparse_src", 32'(out_src), 32'd1);
        cmp("single3_grant", 32'(in_ready), 32'h8);
        step; in_valid = 4'b0000; #1;
        cmp("single3_src", 32'(out_src), 32'd3);
        cmp("single3_valid", 32'(out_valid), 32'h1);
        step; #1;
        cmp("drain_valid", 32'(out_valid), 32'h0);
        cmp("drain_data", out_data, 32'hA3);

        // Randomised traffic, back-pressure and occasional reset.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            rst       = ($urandom_range(0, 99) == 0);
            in_valid  = 4'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < 4; k++) d[k] = $urandom;
        end
        step; #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
